// File: rtl/ariane_pkg.sv
// Core-wide cache geometry constants shared by the data-cache blocks.
//   DCACHE_TAG_WIDTH  : width of a cache tag
//   DCACHE_LINE_WIDTH : width of the data payload of one cache line
package ariane_pkg;

    localparam int unsigned DCACHE_TAG_WIDTH  = 44;
    localparam int unsigned DCACHE_LINE_WIDTH = 128;

endpackage

// File: rtl/std_cache_pkg.sv
// Shared types for the standard data-cache blocks.
//   cache_line_t   : per-way line as read from the tag/data arrays
//   lookup_state_e : sequencing states of the tag lookup requester
package std_cache_pkg;

    typedef struct packed {
        logic [ariane_pkg::DCACHE_TAG_WIDTH-1:0]  tag;
        logic [ariane_pkg::DCACHE_LINE_WIDTH-1:0] data;
        logic                                     valid;
    } cache_line_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CMP,
        RESP
    } lookup_state_e;

endpackage

// File: rtl/tag_lookup_req_if.sv
// Upstream side of the tag lookup requester: lookup request handshake plus
// the response handshake and response payload.
//   master : the client issuing lookups and consuming responses
//   slave  : the lookup requester itself
interface tag_lookup_req_if #(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned DCACHE_SET_ASSOC = 8,
    parameter type         l_data_t         = std_cache_pkg::cache_line_t
);

    logic                                    lookup_valid_i;
    logic                                    lookup_ready_o;
    logic [ADDR_WIDTH-1:0]                   lookup_addr_i;
    logic [ariane_pkg::DCACHE_TAG_WIDTH-1:0] lookup_tag_i;
    logic                                    lookup_kill_i;

    logic                                    resp_valid_o;
    logic                                    resp_ready_i;
    logic                                    resp_hit_o;
    logic                                    resp_multi_hit_o;
    logic [DCACHE_SET_ASSOC-1:0]             resp_way_o;
    l_data_t                                 resp_data_o;

    modport master (
        output lookup_valid_i, lookup_addr_i, lookup_tag_i, lookup_kill_i, resp_ready_i,
        input  lookup_ready_o, resp_valid_o, resp_hit_o, resp_multi_hit_o, resp_way_o,
               resp_data_o
    );

    modport slave (
        input  lookup_valid_i, lookup_addr_i, lookup_tag_i, lookup_kill_i, resp_ready_i,
        output lookup_ready_o, resp_valid_o, resp_hit_o, resp_multi_hit_o, resp_way_o,
               resp_data_o
    );

endinterface

// File: rtl/lzc.sv
// Leading/trailing zero counter.
//   in_i    : input vector
//   cnt_o   : number of trailing zeros (MODE=0) or leading zeros (MODE=1)
//   empty_o : high when in_i is all zeros (cnt_o is then 0)
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // The scan order makes the last match win: for trailing mode that is the
    // lowest set bit, for leading mode the highest.
    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!MODE && in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH-1-i);
            if (MODE && in_i[i])          cnt_o = CNT_WIDTH'(WIDTH-1-i);
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/tag_lookup_req.sv
// Tag lookup requester: accepts one lookup (set address + tag), requests all
// ways of the tag-compare arbiter port, presents the tag in the compare cycle,
// registers the hit information and returns it on a response handshake.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   lk (slave)        : lookup request / response handshakes and payload
//   req_o, gnt_i      : per-way request and grant toward the arbiter
//   addr_o, we_o      : index address (only while requesting), always read
//   tag_o             : lookup tag, driven only in the compare cycle
//   hit_way_i, rdata_i: per-way hit vector and lines, valid in compare cycle
module tag_lookup_req
    import std_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned DCACHE_SET_ASSOC = 8,
    parameter type         l_data_t         = std_cache_pkg::cache_line_t
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    tag_lookup_req_if.slave                         lk,
    output logic [DCACHE_SET_ASSOC-1:0]             req_o,
    input  logic                                    gnt_i,
    output logic [ADDR_WIDTH-1:0]                   addr_o,
    output logic                                    we_o,
    output logic [ariane_pkg::DCACHE_TAG_WIDTH-1:0] tag_o,
    input  logic [DCACHE_SET_ASSOC-1:0]             hit_way_i,
    input  l_data_t [DCACHE_SET_ASSOC-1:0]          rdata_i
);

    localparam int unsigned TAG_W = ariane_pkg::DCACHE_TAG_WIDTH;
    localparam int unsigned IDX_W = (DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1;

    lookup_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [TAG_W-1:0]            tag_q, tag_d;
    logic [DCACHE_SET_ASSOC-1:0] req_q, req_d;
    logic [ADDR_WIDTH-1:0]       addr_out_q, addr_out_d;
    logic [TAG_W-1:0]            tag_out_q, tag_out_d;
    logic                        resp_valid_q, resp_valid_d;
    logic                        resp_hit_q, resp_hit_d;
    logic                        resp_multi_q, resp_multi_d;
    logic [DCACHE_SET_ASSOC-1:0] resp_way_q, resp_way_d;
    l_data_t                     resp_data_q, resp_data_d;
    logic                        lookup_ready;

    logic [IDX_W-1:0]            way_idx;
    logic                        no_hit;
    logic [DCACHE_SET_ASSOC-1:0] way_onehot;
    logic                        multi_hit;

    lzc #(
        .WIDTH (DCACHE_SET_ASSOC),
        .MODE  (1'b0)
    ) i_lzc (
        .in_i    (hit_way_i),
        .cnt_o   (way_idx),
        .empty_o (no_hit)
    );

    // Clearing the lowest set bit leaves something only when two or more ways hit.
    assign multi_hit = (hit_way_i & (hit_way_i - DCACHE_SET_ASSOC'(1))) != '0;

    always_comb begin
        way_onehot = '0;
        if (!no_hit) way_onehot[way_idx] = 1'b1;
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers latches.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        resp_hit_d   = 1'b0;
        resp_multi_d = 1'b0;
        resp_way_d   = '0;
        resp_data_d  = '0;
        lookup_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                lookup_ready = 1'b1;
                if (lk.lookup_valid_i) begin
                    state_d = REQ;
                    addr_d  = lk.lookup_addr_i;
                    tag_d   = lk.lookup_tag_i;
                end
            end
            REQ: begin
                // A grant that coincides with a kill is consumed and dropped.
                if (lk.lookup_kill_i) state_d = IDLE;
                else if (gnt_i)       state_d = CMP;
            end
            CMP: begin
                if (lk.lookup_kill_i) begin
                    state_d = IDLE;
                end else begin
                    state_d      = RESP;
                    resp_hit_d   = !no_hit;
                    resp_multi_d = multi_hit;
                    resp_way_d   = way_onehot;
                    if (!no_hit) resp_data_d = rdata_i[way_idx];
                end
            end
            RESP: begin
                if (lk.lookup_kill_i) begin
                    state_d = IDLE;
                end else if (lk.resp_ready_i) begin
                    // Handshake completes; a new lookup may be taken in the same cycle.
                    lookup_ready = 1'b1;
                    state_d      = IDLE;
                    if (lk.lookup_valid_i) begin
                        state_d = REQ;
                        addr_d  = lk.lookup_addr_i;
                        tag_d   = lk.lookup_tag_i;
                    end
                end else begin
                    resp_hit_d   = resp_hit_q;
                    resp_multi_d = resp_multi_q;
                    resp_way_d   = resp_way_q;
                    resp_data_d  = resp_data_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they are glitch-free
        // and read as zero outside the state that owns them.
        req_d        = (state_d == REQ) ? '1 : '0;
        addr_out_d   = (state_d == REQ) ? addr_d : '0;
        tag_out_d    = (state_d == CMP) ? tag_q : '0;
        resp_valid_d = (state_d == RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the response line is a plain register, not a memory, so it
            // is reset along with the rest; outputs must read zero in reset.
            state_q      <= IDLE;
            addr_q       <= '0;
            tag_q        <= '0;
            req_q        <= '0;
            addr_out_q   <= '0;
            tag_out_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_multi_q <= 1'b0;
            resp_way_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            req_q        <= req_d;
            addr_out_q   <= addr_out_d;
            tag_out_q    <= tag_out_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_multi_q <= resp_multi_d;
            resp_way_q   <= resp_way_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Ready is decoded combinationally (it depends on resp_ready_i in RESP);
    // it is masked while reset is held so all outputs read zero.
    assign lk.lookup_ready_o   = lookup_ready & ~rst_i;
    assign lk.resp_valid_o     = resp_valid_q;
    assign lk.resp_hit_o       = resp_hit_q;
    assign lk.resp_multi_hit_o = resp_multi_q;
    assign lk.resp_way_o       = resp_way_q;
    assign lk.resp_data_o      = resp_data_q;

    assign req_o  = req_q;
    assign addr_o = addr_out_q;
    assign tag_o  = tag_out_q;
    assign we_o   = 1'b0;

endmodule

// File: tb/tb_tag_lookup_req.sv
// Self-checking bench for tag_lookup_req: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level model of the lookup.
module tb_tag_lookup_req;

    import std_cache_pkg::cache_line_t;

    localparam int unsigned AW = 64;
    localparam int unsigned SA = 8;
    localparam int unsigned TW = ariane_pkg::DCACHE_TAG_WIDTH;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    tag_lookup_req_if #(.ADDR_WIDTH(AW), .DCACHE_SET_ASSOC(SA), .l_data_t(cache_line_t)) lk ();

    logic [SA-1:0]          req_o;
    logic                   gnt_i;
    logic [AW-1:0]          addr_o;
    logic                   we_o;
    logic [TW-1:0]          tag_o;
    logic [SA-1:0]          hit_way_i;
    cache_line_t [SA-1:0]   rdata_i;

    tag_lookup_req #(
        .ADDR_WIDTH       (AW),
        .DCACHE_SET_ASSOC (SA),
        .l_data_t         (cache_line_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .lk        (lk),
        .req_o     (req_o),
        .gnt_i     (gnt_i),
        .addr_o    (addr_o),
        .we_o      (we_o),
        .tag_o     (tag_o),
        .hit_way_i (hit_way_i),
        .rdata_i   (rdata_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the next cycle.
    logic                 d_rst, d_valid, d_kill, d_gnt, d_ready;
    logic [AW-1:0]        d_addr;
    logic [TW-1:0]        d_tag;
    logic [SA-1:0]        d_hit;
    cache_line_t [SA-1:0] d_rdata;

    // Model: at most one lookup in flight; stage 0 waits for grant, stage 1 is
    // the compare cycle, stage 2 presents the response.
    bit            busy = 1'b0;
    int            stage = 0;
    logic [AW-1:0] m_addr;
    logic [TW-1:0] m_tag;
    logic          m_hit, m_multi;
    logic [SA-1:0] m_way;
    cache_line_t   m_data;

    cache_line_t   exp_line;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rand_lines();
        for (int w = 0; w < SA; w++) begin
            d_rdata[w].tag   = TW'({$urandom(), $urandom()});
            d_rdata[w].data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            d_rdata[w].valid = 1'($urandom());
        end
    endtask

    task automatic idle_inputs();
        d_rst   = 1'b0;
        d_valid = 1'b0;
        d_kill  = 1'b0;
        d_gnt   = 1'b0;
        d_ready = 1'b0;
        d_addr  = '0;
        d_tag   = '0;
        d_hit   = '0;
        rand_lines();
    endtask

    task automatic apply_inputs();
        rst_i             = d_rst;
        lk.lookup_valid_i = d_valid;
        lk.lookup_addr_i  = d_addr;
        lk.lookup_tag_i   = d_tag;
        lk.lookup_kill_i  = d_kill;
        lk.resp_ready_i   = d_ready;
        gnt_i             = d_gnt;
        hit_way_i         = d_hit;
        rdata_i           = d_rdata;
    endtask

    function automatic logic model_ready();
        return !d_rst && (!busy || (stage == 2 && d_ready && !d_kill));
    endfunction

    task automatic compare_model();
        logic resp_on;
        resp_on = busy && stage == 2;
        check("lookup_ready", 256'(lk.lookup_ready_o), 256'(model_ready()));
        check("req_o", 256'(req_o), (busy && stage == 0) ? 256'({SA{1'b1}}) : 256'(0));
        check("addr_o", 256'(addr_o), (busy && stage == 0) ? 256'(m_addr) : 256'(0));
        check("tag_o", 256'(tag_o), (busy && stage == 1) ? 256'(m_tag) : 256'(0));
        check("we_o", 256'(we_o), 256'(0));
        check("resp_valid", 256'(lk.resp_valid_o), 256'(resp_on));
        check("resp_hit", 256'(lk.resp_hit_o), resp_on ? 256'(m_hit) : 256'(0));
        check("resp_multi", 256'(lk.resp_multi_hit_o), resp_on ? 256'(m_multi) : 256'(0));
        check("resp_way", 256'(lk.resp_way_o), resp_on ? 256'(m_way) : 256'(0));
        check("resp_data", 256'(lk.resp_data_o), resp_on ? 256'(m_data) : 256'(0));
    endtask

    task automatic update_model();
        logic accept;
        accept = d_valid && model_ready();
        if (d_rst) begin
            busy = 1'b0;
        end else if (busy && d_kill) begin
            busy = 1'b0;
        end else if (busy) begin
            if (stage == 0) begin
                if (d_gnt) stage = 1;
            end else if (stage == 1) begin
                m_hit   = (d_hit != '0);
                m_multi = ($countones(d_hit) > 1);
                m_way   = d_hit & (~d_hit + SA'(1));
                if (m_hit) m_data = d_rdata[$clog2(m_way)];
                else       m_data = '0;
                stage = 2;
            end else if (d_ready) begin
                busy = 1'b0;
            end
        end
        if (accept) begin
            busy   = 1'b1;
            stage  = 0;
            m_addr = d_addr;
            m_tag  = d_tag;
        end
    endtask

    // One clock cycle: inputs change just after the edge, outputs are checked
    // mid-cycle, then the model advances as the next edge will.
    task automatic cycle();
        @(posedge clk);
        #1;
        apply_inputs();
        if (d_rst) busy = 1'b0;
        #1;
        compare_model();
        update_model();
    endtask

    task automatic start_lookup(input logic [AW-1:0] a, input logic [TW-1:0] t);
        idle_inputs();
        d_valid = 1'b1;
        d_addr  = a;
        d_tag   = t;
        cycle();
    endtask

    initial begin
        idle_inputs();
        d_rst = 1'b1;
        apply_inputs();

        // Reset state.
        cycle();
        cycle();
        check("rst_ready", 256'(lk.lookup_ready_o), 256'(0));
        check("rst_resp_valid", 256'(lk.resp_valid_o), 256'(0));
        idle_inputs();
        cycle();
        check("idle_ready", 256'(lk.lookup_ready_o), 256'(1));
        check("idle_req", 256'(req_o), 256'(0));

        // Single-way hit, grant in the first request cycle.
        start_lookup(64'h40, 44'h12);
        check("t1_accept_ready", 256'(lk.lookup_ready_o), 256'(1));
        idle_inputs(); d_gnt = 1'b1; cycle();
        check("t1_req", 256'(req_o), 256'(8'hFF));
        check("t1_addr", 256'(addr_o), 256'(64'h40));
        idle_inputs(); d_hit = 8'b0000_0100; exp_line = d_rdata[2]; cycle();
        check("t1_tag", 256'(tag_o), 256'(44'h12));
        check("t1_not_yet_valid", 256'(lk.resp_valid_o), 256'(0));
        idle_inputs(); d_ready = 1'b1; cycle();
        check("t1_valid_c3", 256'(lk.resp_valid_o), 256'(1));
        check("t1_hit", 256'(lk.resp_hit_o), 256'(1));
        check("t1_multi", 256'(lk.resp_multi_hit_o), 256'(0));
        check("t1_way", 256'(lk.resp_way_o), 256'(8'h04));
        check("t1_data", 256'(lk.resp_data_o), 256'(exp_line));
        idle_inputs(); cycle();
        check("t1_done", 256'(lk.resp_valid_o), 256'(0));

        // Grant withheld four cycles, then a multi-way hit.
        start_lookup(64'hDEAD_BEEF_0000_1000, 44'hABC);
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); cycle();
            check("t2_req_held", 256'(req_o), 256'(8'hFF));
            check("t2_addr_held", 256'(addr_o), 256'(64'hDEAD_BEEF_0000_1000));
        end
        idle_inputs(); d_gnt = 1'b1; cycle();
        idle_inputs(); d_hit = 8'b1001_0000; exp_line = d_rdata[4]; cycle();
        check("t2_valid_grant_plus1", 256'(lk.resp_valid_o), 256'(0));
        idle_inputs(); d_ready = 1'b1; cycle();
        check("t2_valid_grant_plus2", 256'(lk.resp_valid_o), 256'(1));
        check("t2_hit", 256'(lk.resp_hit_o), 256'(1));
        check("t2_multi", 256'(lk.resp_multi_hit_o), 256'(1));
        check("t2_way", 256'(lk.resp_way_o), 256'(8'h10));
        check("t2_data", 256'(lk.resp_data_o), 256'(exp_line));

        // Miss with response back-pressure.
        start_lookup(64'h80, 44'h7);
        idle_inputs(); d_gnt = 1'b1; cycle();
        idle_inputs(); cycle();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); cycle();
            check("t3_valid_held", 256'(lk.resp_valid_o), 256'(1));
            check("t3_miss", 256'(lk.resp_hit_o), 256'(0));
            check("t3_data_zero", 256'(lk.resp_data_o), 256'(0));
        end
        idle_inputs(); d_ready = 1'b1; cycle();
        check("t3_handshake", 256'(lk.resp_valid_o), 256'(1));
        idle_inputs(); cycle();
        check("t3_released", 256'(lk.resp_valid_o), 256'(0));

        // Kill together with the grant, then a clean lookup.
        start_lookup(64'hC0, 44'h55);
        idle_inputs(); d_gnt = 1'b1; d_kill = 1'b1; cycle();
        idle_inputs(); cycle();
        check("t4_tag_zero", 256'(tag_o), 256'(0));
        check("t4_no_valid", 256'(lk.resp_valid_o), 256'(0));
        check("t4_idle_ready", 256'(lk.lookup_ready_o), 256'(1));
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); cycle();
        end
        start_lookup(64'h100, 44'h66);
        idle_inputs(); d_gnt = 1'b1; cycle();
        idle_inputs(); d_hit = 8'b0000_0001; cycle();
        idle_inputs(); d_ready = 1'b1; cycle();
        check("t4_relookup_way", 256'(lk.resp_way_o), 256'(8'h01));

        // Reset pulsed in the compare cycle.
        start_lookup(64'h140, 44'h99);
        idle_inputs(); d_gnt = 1'b1; cycle();
        idle_inputs(); d_hit = 8'h01; cycle();
        rst_i = 1'b1;
        #1;
        busy = 1'b0;
        check("t5_rst_tag", 256'(tag_o), 256'(0));
        check("t5_rst_req", 256'(req_o), 256'(0));
        check("t5_rst_valid", 256'(lk.resp_valid_o), 256'(0));
        check("t5_rst_ready", 256'(lk.lookup_ready_o), 256'(0));
        idle_inputs(); d_rst = 1'b1; cycle();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); d_ready = 1'b1; cycle();
        end
        check("t5_no_resp", 256'(lk.resp_valid_o), 256'(0));

        // Back-to-back accept while the response is taken.
        start_lookup(64'h180, 44'h11);
        idle_inputs(); d_gnt = 1'b1; cycle();
        idle_inputs(); d_hit = 8'h02; cycle();
        idle_inputs(); d_ready = 1'b1; d_valid = 1'b1; d_addr = 64'h1C0; d_tag = 44'h22; cycle();
        check("t6_b2b_ready", 256'(lk.lookup_ready_o), 256'(1));
        idle_inputs(); cycle();
        check("t6_b2b_req", 256'(req_o), 256'(8'hFF));
        check("t6_b2b_addr", 256'(addr_o), 256'(64'h1C0));
        idle_inputs(); d_gnt = 1'b1; cycle();
        idle_inputs(); d_hit = 8'h80; cycle();
        idle_inputs(); d_ready = 1'b1; cycle();
        check("t6_b2b_way", 256'(lk.resp_way_o), 256'(8'h80));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            d_rst   = ($urandom_range(0, 299) == 0);
            d_valid = 1'($urandom_range(0, 1));
            d_kill  = ($urandom_range(0, 19) == 0);
            d_gnt   = ($urandom_range(0, 2) != 0);
            d_ready = ($urandom_range(0, 2) != 0);
            d_addr  = {$urandom(), $urandom()};
            d_tag   = TW'({$urandom(), $urandom()});
            case ($urandom_range(0, 3))
                0:       d_hit = '0;
                1:       d_hit = SA'(1) << $urandom_range(0, SA - 1);
                default: d_hit = SA'($urandom());
            endcase
            rand_lines();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_lookup_req.md
TAG_LOOKUP_REQ -- requirements
Module: tag_lookup_req

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, width of the set-index/address sent to the tag-compare arbiter.
REQ-002 SHALL have parameter DCACHE_SET_ASSOC, default 8, number of ways.
REQ-003 SHALL have parameter l_data_t, default std_cache_pkg::cache_line_t, per-way line type carrying .tag, .valid and .data.
REQ-004 SHALL have clk_i, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have lookup_valid_i / lookup_ready_o, input/output, 1/1, upstream lookup handshake.
REQ-007 SHALL have lookup_addr_i, input, ADDR_WIDTH, index address of the lookup.
REQ-008 SHALL have lookup_tag_i, input, ariane_pkg::DCACHE_TAG_WIDTH, tag to compare, sampled with lookup_addr_i.
REQ-009 SHALL have lookup_kill_i, input, 1, abort the in-flight lookup.
REQ-010 SHALL have resp_valid_o / resp_ready_i, output/input, 1/1, response handshake.
REQ-011 SHALL have resp_hit_o, resp_multi_hit_o, output, 1 each, hit and multi-way-hit error flags.
REQ-012 SHALL have resp_way_o, output, DCACHE_SET_ASSOC, one-hot hitting way (lowest if several).
REQ-013 SHALL have resp_data_o, output, l_data_t, line from the hitting way, '0 on miss.
REQ-014 SHALL have req_o, output, DCACHE_SET_ASSOC, per-way request toward the arbiter port.
REQ-015 SHALL have gnt_i, input, 1, arbiter grant for this port.
REQ-016 SHALL have addr_o, output, ADDR_WIDTH; we_o, output, 1 (constant 0, read-only lookups).
REQ-017 SHALL have tag_o, output, ariane_pkg::DCACHE_TAG_WIDTH, tag presented one cycle after grant.
REQ-018 SHALL have hit_way_i, input, DCACHE_SET_ASSOC, and rdata_i, input, DCACHE_SET_ASSOC x l_data_t, valid in the cycle after grant.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, CMP, RESP.
REQ-020 IDLE: lookup_ready_o=1; on lookup_valid_i capture addr/tag into registers, go REQ.
REQ-021 REQ: req_o all ones, addr_o = captured addr; gnt_i=1 -> CMP; else stay, request and address held stable.
REQ-022 CMP: tag_o = captured tag; register hit_way_i, rdata_i-selected line and flags; go RESP.
REQ-023 RESP: resp_valid_o=1, response outputs stable until resp_ready_i; on resp_ready_i go IDLE.
REQ-024 RESP with resp_ready_i=1: lookup_ready_o=1; a simultaneous lookup_valid_i is accepted and next state is REQ (back-to-back, no IDLE bubble).
REQ-025 Minimum latency: accept at cycle 0, gnt at cycle 1, resp_valid_o at cycle 3.
REQ-026 resp_hit_o = |hit_way_i; resp_multi_hit_o = popcount(hit_way_i)>1; resp_way_o = lowest set bit only.
REQ-027 lookup_kill_i in REQ, CMP or RESP -> IDLE next cycle, no response issued; kill in IDLE ignored.
REQ-028 Kill coinciding with gnt_i in REQ: grant consumed, still go IDLE, tag_o not driven (0) next cycle.
REQ-029 Outside REQ req_o=0 and addr_o=0; outside CMP tag_o=0.

Reset
REQ-030 rst_i SHALL force IDLE immediately, clearing captured addr/tag and registered response; all outputs 0 except lookup_ready_o=1 once rst_i deasserts.
REQ-031 Reset mid-lookup SHALL drop the lookup silently; no response after reset release.

Structure
REQ-032 State enum lookup_state_e SHALL live in std_cache_pkg; tag width from ariane_pkg::DCACHE_TAG_WIDTH.
REQ-033 Lowest-hit-way selection SHALL use one instance of the common-cells leading-zero counter lzc.

Verification
REQ-034 Lookup addr=0x40, tag=0x12, gnt immediate, hit_way_i=8'b0000_0100 -> resp_valid at cycle 3, resp_hit=1, resp_way=0x04, resp_data=rdata_i[2].
REQ-035 gnt_i withheld 4 cycles -> req_o=0xFF and addr_o stable all 4 cycles; resp_valid 2 cycles after grant.
REQ-036 hit_way_i=8'b1001_0000 -> resp_hit=1, resp_multi_hit=1, resp_way=0x10.
REQ-037 hit_way_i=0 -> resp_hit=0, resp_data=0; resp_ready_i held low 3 cycles -> outputs stable, then handshake completes.
REQ-038 Kill asserted in the grant cycle -> no resp_valid, tag_o=0, FSM IDLE; new lookup then completes normally.
REQ-039 rst_i pulsed in CMP -> all outputs 0 same cycle, no response after release; back-to-back accept in RESP yields REQ without bubble.
